// File: rtl/map_pkg.sv
// Shared types, constants and address helper for the game-map tile RAM write path.
package map_pkg;

  localparam int TILE_W = 4;
  localparam int MAP_W  = 40;
  localparam int MAP_H  = 30;

  typedef logic [TILE_W-1:0] tile_t;

  localparam tile_t TILE_EMPTY  = 4'h0;
  localparam tile_t TILE_PACMAN = 4'h2;
  localparam tile_t TILE_GHOST  = 4'h3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_ERASE,
    ST_WRITE,
    ST_DONE
  } arb_state_t;

  // Linear tile address; callers truncate to their RAM address width.
  function automatic int unsigned tile_addr(input logic [5:0] x, input logic [4:0] y,
                                            input int unsigned map_w);
    return 32'(y) * map_w + 32'(x);
  endfunction

endpackage

// File: rtl/map_write_arbiter_if.sv
// Requester and RAM write-port signals of the map write arbiter.
interface map_wr_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 11,
  parameter int TILE_W  = 4
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*6-1:0]      curr_x;
  logic [NUM_REQ*5-1:0]      curr_y;
  logic [NUM_REQ*6-1:0]      next_x;
  logic [NUM_REQ*5-1:0]      next_y;
  logic [NUM_REQ*TILE_W-1:0] sprite_tile;
  logic                      ram_ready;
  logic                      ram_wr_en;
  logic [ADDR_W-1:0]         ram_addr;
  logic [TILE_W-1:0]         ram_wr_data;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        done;
  logic                      busy;

  modport slave (
    input  req, curr_x, curr_y, next_x, next_y, sprite_tile, ram_ready,
    output ram_wr_en, ram_addr, ram_wr_data, grant, done, busy
  );

  modport master (
    output req, curr_x, curr_y, next_x, next_y, sprite_tile, ram_ready,
    input  ram_wr_en, ram_addr, ram_wr_data, grant, done, busy
  );
endinterface

// File: rtl/map_write_arbiter_rr_arbiter.sv
// Combinational rotating-priority arbiter: first set request at or above ptr_i, wrapping.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]                   req_i,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0] ptr_i,
  output logic [N-1:0]                   gnt_o
);

  always_comb begin
    logic found;
    int   idx;
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr_i) + i) % N;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/map_write_arbiter.sv
// Shares the tile RAM write port between sprite movers: round-robin grant,
// erase old tile, write sprite tile at the new position, pulse done.
module map_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int MAP_W   = map_pkg::MAP_W,
  parameter int ADDR_W  = 11,
  parameter int TILE_W  = map_pkg::TILE_W
) (
  input logic      CLOCK_50,
  input logic      reset_n,
  map_wr_if.slave  bus
);
  import map_pkg::tile_addr;

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  map_pkg::arb_state_t state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d, own_q, own_d, arb_idx;
  logic [ADDR_W-1:0]   a_curr_q, a_curr_d, a_next_q, a_next_d, a_curr_w, a_next_w;
  logic [TILE_W-1:0]   tile_q, tile_d, tile_w;
  logic [NUM_REQ-1:0]  arb_gnt, own_oh;

  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [TILE_W-1:0]   wr_data;
  logic [NUM_REQ-1:0]  grant, done;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req_i (bus.req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt)
  );

  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) arb_idx = PW'(i);
    end
  end

  assign own_oh = NUM_REQ'(1) << own_q;

  // Owner's live inputs; only consumed while in LATCH.
  assign a_curr_w = ADDR_W'(tile_addr(bus.curr_x[6*int'(own_q) +: 6],
                                      bus.curr_y[5*int'(own_q) +: 5], MAP_W));
  assign a_next_w = ADDR_W'(tile_addr(bus.next_x[6*int'(own_q) +: 6],
                                      bus.next_y[5*int'(own_q) +: 5], MAP_W));
  assign tile_w   = bus.sprite_tile[TILE_W*int'(own_q) +: TILE_W];

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= map_pkg::ST_IDLE;
      ptr_q    <= '0;
      own_q    <= '0;
      a_curr_q <= '0;
      a_next_q <= '0;
      tile_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      own_q    <= own_d;
      a_curr_q <= a_curr_d;
      a_next_q <= a_next_d;
      tile_q   <= tile_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    own_d    = own_q;
    a_curr_d = a_curr_q;
    a_next_d = a_next_q;
    tile_d   = tile_q;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    grant    = '0;
    done     = '0;
    unique case (state_q)
      map_pkg::ST_IDLE: begin
        if (|bus.req) begin
          own_d   = arb_idx;
          state_d = map_pkg::ST_LATCH;
        end
      end
      map_pkg::ST_LATCH: begin
        grant    = own_oh;
        a_curr_d = a_curr_w;
        a_next_d = a_next_w;
        tile_d   = tile_w;
        // A blocked move redraws in place; erasing first would only flicker.
        state_d  = (a_curr_w == a_next_w) ? map_pkg::ST_WRITE : map_pkg::ST_ERASE;
      end
      map_pkg::ST_ERASE: begin
        grant   = own_oh;
        wr_en   = 1'b1;
        wr_addr = a_curr_q;
        wr_data = TILE_W'(map_pkg::TILE_EMPTY);
        if (bus.ram_ready) state_d = map_pkg::ST_WRITE;
      end
      map_pkg::ST_WRITE: begin
        grant   = own_oh;
        wr_en   = 1'b1;
        wr_addr = a_next_q;
        wr_data = tile_q;
        if (bus.ram_ready) state_d = map_pkg::ST_DONE;
      end
      map_pkg::ST_DONE: begin
        grant   = own_oh;
        done    = own_oh;
        ptr_d   = (int'(own_q) == NUM_REQ - 1) ? '0 : own_q + PW'(1);
        state_d = map_pkg::ST_IDLE;
      end
      default: state_d = map_pkg::ST_IDLE;
    endcase
  end

  assign bus.ram_wr_en   = wr_en;
  assign bus.ram_addr    = wr_addr;
  assign bus.ram_wr_data = wr_data;
  assign bus.grant       = grant;
  assign bus.done        = done;
  assign bus.busy        = (state_q != map_pkg::ST_IDLE);

endmodule
